// File: rtl/fetch.sv
// Fetch stage: owns the PC, runs the imem req/ack handshake, and feeds the F/D register.
// A one-entry buffer (HOLD state) absorbs decode stalls; DRAIN finishes requests squashed by redirects.
module fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_StallD,
  input  logic        i_FlushD,
  input  logic        i_BranchTaken_E,
  input  logic [31:0] i_ALUResult_E,
  input  logic        i_PCSrc_W,
  input  logic [31:0] i_Result_W,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_Instruction_D,
  output logic [31:0] o_PCPlus8_D,
  output logic        o_Valid_D
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

  state_t      state_q;
  logic [31:0] pc_q, drain_addr_q, buf_instr_q, buf_pc_q;
  logic [31:0] instr_q, pcplus8_q;
  logic        valid_q;
  logic [31:0] instr_d, pcplus8_d;
  logic        valid_d;

  logic        redirect;
  logic [31:0] target;
  logic        dlv_vld;
  logic [31:0] dlv_instr, dlv_pc;

  assign redirect = i_BranchTaken_E | i_PCSrc_W;
  assign target   = (i_BranchTaken_E ? i_ALUResult_E : i_Result_W) & 32'hFFFF_FFFC;

  // Candidate instruction for F/D this cycle; the buffer only holds data while in HOLD.
  always_comb begin
    dlv_vld   = 1'b0;
    dlv_instr = NOP_INSTR;
    dlv_pc    = '0;
    if (state_q == REQ && i_imem_ack) begin
      dlv_vld   = 1'b1;
      dlv_instr = i_imem_rdata;
      dlv_pc    = pc_q;
    end else if (state_q == HOLD) begin
      dlv_vld   = 1'b1;
      dlv_instr = buf_instr_q;
      dlv_pc    = buf_pc_q;
    end
  end

  always_comb begin
    instr_d   = NOP_INSTR;
    pcplus8_d = '0;
    valid_d   = 1'b0;
    if (i_FlushD) begin
      instr_d   = NOP_INSTR;
    end else if (i_StallD) begin
      instr_d   = instr_q;
      pcplus8_d = pcplus8_q;
      valid_d   = valid_q;
    end else if (!redirect && dlv_vld) begin
      instr_d   = dlv_instr;
      pcplus8_d = dlv_pc + 32'd8;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      buf_instr_q  <= NOP_INSTR;
      buf_pc_q     <= '0;
      instr_q      <= NOP_INSTR;
      pcplus8_q    <= '0;
      valid_q      <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pcplus8_q <= pcplus8_d;
      valid_q   <= valid_d;
      if (redirect) pc_q <= target;
      unique case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (redirect) begin
            // An unacked request must still complete, so park its address and drain it.
            if (!i_imem_ack) begin
              drain_addr_q <= pc_q;
              state_q      <= DRAIN;
            end
          end else if (i_imem_ack) begin
            pc_q <= pc_q + 32'd4;
            if (i_StallD) begin
              buf_instr_q <= i_imem_rdata;
              buf_pc_q    <= pc_q;
              state_q     <= HOLD;
            end
          end
        end
        HOLD: if (redirect || !i_StallD) state_q <= REQ;
        DRAIN: if (i_imem_ack) state_q <= REQ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_imem_req      = (state_q == REQ) || (state_q == DRAIN);
  assign o_imem_addr     = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign o_Instruction_D = instr_q;
  assign o_PCPlus8_D     = pcplus8_q;
  assign o_Valid_D       = valid_q;

endmodule
